// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: receiver FSM encoding and bit-timing helpers
//
// Contents:
//   uart_state_e  receiver FSM states (IDLE, START, DATA, STOP, BREAK_WAIT)
//   calc_div      clock cycles per serial bit, CLK_MHZ*1e6/BAUD truncated
//   calc_cnt_w    bit-timing counter width able to hold DIV without overflow

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } uart_state_e;

    function automatic int calc_div(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

    // Counter must represent DIV itself, hence DIV+1 distinct values.
    function automatic int calc_cnt_w(input int div);
        return (div < 1) ? 1 : $clog2(div + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with wrap-bit full/empty detection
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   push, push_data  write request and byte; ignored while full unless pop is also high
//   pop              remove head entry; ignored while empty
//   pop_data         head entry
//   empty, full      occupancy flags

module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra top bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot the push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with buffered byte output
//
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   rx           asynchronous serial line, idles high
//   recv_data    byte at buffer head, valid while recv_valid is high
//   recv_valid   at least one byte buffered
//   recv_ack     pops the head byte when recv_valid is high
//   frame_err    one-cycle pulse when a stop bit samples low
//   overrun      one-cycle pulse when a completed byte is dropped on a full buffer
//
// Configuration:
//   UART_RX_FIFO_EN defined   -> FIFO_DEPTH-entry FIFO (uart_rx_fifo)
//   UART_RX_FIFO_EN undefined -> single holding register, FIFO_DEPTH unused

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] recv_data,
    output logic       recv_valid,
    input  logic       recv_ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV   = calc_div(CLK_MHZ, BAUD);
    localparam int CNT_W = calc_cnt_w(DIV);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    uart_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift_reg, shift_n;
    logic             push;
    logic             ferr_n;
    logic             pop;
    logic             buf_full;

    logic             rx_meta;
    logic             rx_s;
    logic [1:0]       sync_fill;
    logic             line_armed;

    // Synchronizer flops reset high so the line looks idle while they refill.
    // sync_fill marks when rx_s reflects the real line again; line_armed then
    // requires the line to be seen high before any falling edge counts, so a
    // line that is low at reset release cannot start a frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            sync_fill  <= 2'b00;
            line_armed <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            sync_fill  <= {sync_fill[0], 1'b1};
            line_armed <= line_armed | (sync_fill[1] & rx_s);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shift_reg <= shift_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift_reg;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (line_armed && !rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject short glitches.
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift_reg[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK_WAIT;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK_WAIT: begin
                // Swallow a held-low break so it yields only one frame_err.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign pop = recv_ack && recv_valid;

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shift_reg),
        .pop       (pop),
        .pop_data  (recv_data),
        .empty     (fifo_empty),
        .full      (buf_full)
    );

    assign recv_valid = !fifo_empty;
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push && (!hold_valid || pop)) begin
            hold_data  <= shift_reg;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_full   = hold_valid;
    assign recv_valid = hold_valid;
    assign recv_data  = hold_data;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push && buf_full && !pop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a queue model of the receive buffer

module tb_uart_rx;

    localparam int DIV = 104;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       recv_ack = 1'b0;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_MHZ    (12),
        .BAUD       (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .recv_ack   (recv_ack),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         lat = 0;
    logic [7:0] model_q[$];

    always @(negedge clk) begin
        if (resetn) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame; index 0 is the negedge where the start bit begins.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int ack_at,
                              output int valid_at, output bit saw_low);
        logic [9:0] bits;
        bits = {stop_val, b, 1'b0};
        valid_at = -1;
        saw_low = 1'b0;
        for (int k = 0; k < 10 * DIV; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (recv_valid && valid_at < 0) valid_at = k;
                if (!recv_valid) saw_low = 1'b1;
            end
            rx = bits[k / DIV];
            recv_ack = (k == ack_at);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ovr++;
    endtask

    task automatic do_ack;
        recv_ack = 1'b1;
        @(negedge clk);
        recv_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        idle(5);
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", recv_valid); end
        n_checks++; if (recv_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", recv_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", overrun); end
        resetn = 1'b1;
        idle(2 * DIV);
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got %b want 0", recv_valid); end
    endtask

    task automatic test_basic;
        int va;
        bit sl;
        send_frame(8'h55, 1'b1, -1, va, sl);
        model_push(8'h55);
        lat = va;
        n_checks++;
        if (va < (17 * DIV) / 2 || va > (21 * DIV) / 2) begin
            n_fail++; $display("FAIL basic_latency got %0d cycles want %0d..%0d", va, (17 * DIV) / 2, (21 * DIV) / 2);
        end
        n_checks++; if (recv_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", recv_valid); end
        n_checks++; if (recv_data !== model_q[0]) begin n_fail++; $display("FAIL basic_data got %h want %h", recv_data, model_q[0]); end
        n_checks++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL basic_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        do_ack;
        void'(model_q.pop_front());
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got %b want 0", recv_valid); end
    endtask

    task automatic test_glitch;
        int va;
        bit sl;
        rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(3 * DIV);
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid got %b want 0", recv_valid); end
        n_checks++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL glitch_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        send_frame(8'hA3, 1'b1, -1, va, sl);
        model_push(8'hA3);
        n_checks++; if (recv_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_next_valid got %b want 1", recv_valid); end
        n_checks++; if (recv_data !== model_q[0]) begin n_fail++; $display("FAIL glitch_next_data got %h want %h", recv_data, model_q[0]); end
        do_ack;
        void'(model_q.pop_front());
    endtask

    task automatic test_break;
        int va;
        bit sl;
        send_frame(8'h0F, 1'b0, -1, va, sl);
        exp_ferr++;
        idle(2000);
        n_checks++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL break_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL break_valid got %b want 0", recv_valid); end
        rx = 1'b1;
        idle(DIV);
        n_checks++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL break_release_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        send_frame(8'h81, 1'b1, -1, va, sl);
        model_push(8'h81);
        n_checks++; if (recv_data !== model_q[0]) begin n_fail++; $display("FAIL break_next_data got %h want %h", recv_data, model_q[0]); end
        do_ack;
        void'(model_q.pop_front());
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL break_next_pop got %b want 0", recv_valid); end
    endtask

    task automatic test_overrun;
        int va;
        bit sl;
        logic [7:0] b;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, -1, va, sl);
            model_push(b);
            idle($urandom_range(2, 40));
            n_checks++; if (ovr_cnt !== exp_ovr) begin n_fail++; $display("FAIL overrun_count byte %0d got %0d want %0d", i, ovr_cnt, exp_ovr); end
        end
        while (model_q.size() > 0) begin
            n_checks++; if (recv_data !== model_q[0] || recv_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_drain got %h/%b want %h/1", recv_data, recv_valid, model_q[0]); end
            do_ack;
            void'(model_q.pop_front());
        end
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_empty got %b want 0", recv_valid); end
    endtask

    task automatic test_push_pop_full;
        int va;
        bit sl;
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, -1, va, sl);
            model_push(b);
        end
        b = 8'($urandom);
        send_frame(b, 1'b1, lat - 1, va, sl);
        void'(model_q.pop_front());
        model_push(b);
        n_checks++; if (ovr_cnt !== exp_ovr) begin n_fail++; $display("FAIL pushpop_overrun got %0d want %0d", ovr_cnt, exp_ovr); end
        n_checks++; if (sl !== 1'b0) begin n_fail++; $display("FAIL pushpop_valid_gap got %b want 0", sl); end
        n_checks++; if (recv_data !== model_q[0]) begin n_fail++; $display("FAIL pushpop_head got %h want %h", recv_data, model_q[0]); end
        while (model_q.size() > 0) begin
            n_checks++; if (recv_data !== model_q[0] || recv_valid !== 1'b1) begin n_fail++; $display("FAIL pushpop_drain got %h/%b want %h/1", recv_data, recv_valid, model_q[0]); end
            do_ack;
            void'(model_q.pop_front());
        end
    endtask

    task automatic test_random;
        int va;
        bit sl;
        logic [7:0] b;
        int npop;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, -1, va, sl);
            model_push(b);
            idle($urandom_range(1, 50));
            n_checks++; if (ovr_cnt !== exp_ovr) begin n_fail++; $display("FAIL random_overrun iter %0d got %0d want %0d", i, ovr_cnt, exp_ovr); end
            npop = $urandom_range(0, 2);
            for (int j = 0; j < npop; j++) begin
                if (model_q.size() > 0) begin
                    n_checks++; if (recv_valid !== 1'b1 || recv_data !== model_q[0]) begin n_fail++; $display("FAIL random_pop iter %0d got %h/%b want %h/1", i, recv_data, recv_valid, model_q[0]); end
                    do_ack;
                    void'(model_q.pop_front());
                end else begin
                    do_ack;
                    n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL random_idle_ack iter %0d got %b want 0", i, recv_valid); end
                end
            end
        end
        while (model_q.size() > 0) begin
            n_checks++; if (recv_data !== model_q[0] || recv_valid !== 1'b1) begin n_fail++; $display("FAIL random_drain got %h/%b want %h/1", recv_data, recv_valid, model_q[0]); end
            do_ack;
            void'(model_q.pop_front());
        end
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL random_empty got %b want 0", recv_valid); end
    endtask

    task automatic test_reset_midframe;
        int va;
        bit sl;
        logic [7:0] part;
        part = 8'h2C;
        send_frame(8'h11, 1'b1, -1, va, sl);
        model_push(8'h11);
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            idle(DIV);
        end
        rx = part[4];
        idle(DIV / 2);
        resetn = 1'b0;
        idle(8);
        model_q.delete();
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", recv_valid); end
        n_checks++; if (recv_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data got %h want 00", recv_data); end
        resetn = 1'b1;
        idle(300);
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_low_line got %b want 0", recv_valid); end
        rx = 1'b1;
        idle(12 * DIV);
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_spurious got %b want 0", recv_valid); end
        n_checks++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL midreset_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        send_frame(8'h7E, 1'b1, -1, va, sl);
        model_push(8'h7E);
        n_checks++; if (recv_valid !== 1'b1 || recv_data !== model_q[0]) begin n_fail++; $display("FAIL midreset_next got %h/%b want %h/1", recv_data, recv_valid, model_q[0]); end
        do_ack;
        void'(model_q.pop_front());
        n_checks++; if (recv_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_only_one got %b want 0", recv_valid); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_break;
        test_overrun;
        test_push_pop_full;
        test_random;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_MHZ, default 12: system clock frequency in MHz.
REQ-002 Parameter BAUD, default 115200: serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two, minimum 2: receive buffer entries when UART_RX_FIFO_EN is defined.
REQ-004 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 recv_data  output  8  received byte at the buffer head; valid only while recv_valid is high.
REQ-008 recv_valid  output  1  high while at least one byte is buffered.
REQ-009 recv_ack  input  1  pops the head byte when sampled high while recv_valid is high.
REQ-010 frame_err  output  1  one-cycle pulse when a frame's stop bit samples low.
REQ-011 overrun  output  1  one-cycle pulse when a completed byte is dropped because the buffer is full.

Function
REQ-012 DIV SHALL be CLK_MHZ*1000000/BAUD, integer-truncated; it equals 104 at the defaults.
REQ-013 rx SHALL pass through a two-flop synchronizer; all references to the line below mean the synchronizer output (rx_s).
REQ-014 The FSM states SHALL be IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-015 IDLE: rx_s low SHALL clear the bit counter and move to START.
REQ-016 START: at count DIV/2, rx_s high (glitch) SHALL return to IDLE with no output; rx_s low SHALL reset the counter and move to DATA.
REQ-017 DATA: every DIV cycles one bit SHALL be sampled, LSB first, into a shift register; after bit 7 the FSM SHALL move to STOP.
REQ-018 STOP: after DIV cycles, rx_s high SHALL push the byte and go to IDLE.
REQ-019 STOP: after DIV cycles, rx_s low SHALL pulse frame_err, discard the byte and go to BREAK_WAIT.
REQ-020 BREAK_WAIT SHALL move to IDLE on the first cycle rx_s is high; a held-low break SHALL produce exactly one frame_err.
REQ-021 The push SHALL be visible as recv_valid=1 on the cycle after the stop-bit sample.
REQ-022 Push while full and no pop on the same cycle SHALL drop the new byte, pulse overrun and leave buffer contents unchanged.
REQ-023 Push and pop on the same cycle SHALL both take effect, with no overrun, even when the buffer is full.
REQ-024 recv_ack while recv_valid is low SHALL be ignored.
REQ-025 recv_data SHALL hold steady until the byte is popped.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from an extra pointer wrap bit.
REQ-027 The bit counter SHALL be wide enough for DIV without overflow.

Reset
REQ-028 While resetn is low: FSM=IDLE; counters, FIFO pointers and shift register = 0; recv_valid=0, recv_data=0, frame_err=0, overrun=0; synchronizer flops = 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame and empty the buffer.
REQ-030 After reset release, reception SHALL start only on a fresh falling edge.

Configuration
REQ-031 Macro UART_RX_FIFO_EN defined: buffer is a FIFO of FIFO_DEPTH entries per REQ-022..026.
REQ-032 UART_RX_FIFO_EN undefined: buffer is a single holding register, full whenever recv_valid=1; REQ-022/023 apply with depth 1; FIFO_DEPTH is ignored.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state encoding and the DIV/counter-width calculation, shared with the existing transmitter.
REQ-034 The FIFO SHALL be sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification
REQ-035 Defaults; send 0x55 at 104 cycles/bit -> recv_valid rises 9.5±1 bit times after the start edge; recv_data=0x55; frame_err=0.
REQ-036 Line low for 30 cycles, then high -> no recv_valid, no frame_err; FSM back in IDLE; a following 0xA3 frame is received correctly.
REQ-037 Frame 0x0F with stop bit low, line held low for 2000 cycles -> exactly one frame_err pulse, no push; a following 0x81 frame is received.
REQ-038 FIFO_EN, depth 4, no ack; send 0x01..0x05 -> one overrun on the fifth; pops return 0x01..0x04, then recv_valid=0.
REQ-039 Buffer full; recv_ack asserted on the same cycle as a push -> no overrun; the head advances; the new byte is at the tail.
REQ-040 resetn low during data bit 4, released, then 0x7E sent -> recv_valid stays low until 0x7E is received; only 0x7E is returned.
